// File: rtl/aq_djpeg_mcu_sched.sv
// Raster-order MCU/block scheduler: one descriptor per 8x8 block, restart and DC-predictor sequencing.
// BlkValid one cycle after ImageEnable sampled; descriptor held under BlkReady backpressure.
// Optional restart (DRI) handling built only with AQ_DJPEG_MCU_SCHED_DRI_EN defined.
module aq_djpeg_mcu_sched #(
   parameter int MCU_W = 12,
   parameter int RST_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ImageEnable,
   input  logic [2:0]       JpegComp,
   input  logic [MCU_W-1:0] McuWidth,
   input  logic [MCU_W-1:0] McuHeight,
   input  logic [RST_W-1:0] RestartInterval,
   output logic             BlkValid,
   input  logic             BlkReady,
   input  logic             BlkDone,
   output logic [1:0]       BlkComp,
   output logic [2:0]       BlkIndex,
   output logic             DqtSel,
   output logic [1:0]       DhtDcSel,
   output logic [1:0]       DhtAcSel,
   output logic [MCU_W-1:0] McuX,
   output logic [MCU_W-1:0] McuY,
   output logic             RstMarkerReq,
   input  logic             RstMarkerAck,
   output logic             DcPredClr,
   output logic             SchedDone,
   output logic             SchedIdle
);

   typedef enum logic [2:0] {
      S_Idle, S_Issue, S_Wait, S_Next, S_Restart, S_Done
   } state_t;

   state_t           state_q, state_d;
   logic [MCU_W-1:0] mcu_x_q, mcu_x_d;
   logic [MCU_W-1:0] mcu_y_q, mcu_y_d;
   logic [2:0]       blk_idx_q, blk_idx_d;
   logic [1:0]       comp_q, comp_d;
   logic             dqt_q, dqt_d;
   logic [1:0]       dc_sel_q, dc_sel_d;
   logic [1:0]       ac_sel_q, ac_sel_d;
   logic             clr_q, clr_d;
   logic             done_q, done_d;
   logic [2:0]       last_idx;
   logic             last_x, last_y;
`ifdef AQ_DJPEG_MCU_SCHED_DRI_EN
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
`else
   logic             unused_dri;
   assign unused_dri = ^{RestartInterval, RstMarkerAck};
`endif

   function automatic logic [1:0] comp_of(input logic [2:0] idx, input logic is420);
      logic [1:0] c;
      c = 2'd0;
      if (is420 && idx == 3'd4) c = 2'd1;
      if (is420 && idx == 3'd5) c = 2'd2;
      return c;
   endfunction

   always_comb begin
      state_d   = state_q;
      mcu_x_d   = mcu_x_q;
      mcu_y_d   = mcu_y_q;
      blk_idx_d = blk_idx_q;
      comp_d    = comp_q;
      dqt_d     = dqt_q;
      dc_sel_d  = dc_sel_q;
      ac_sel_d  = ac_sel_q;
      clr_d     = 1'b0;
      done_d    = 1'b0;
`ifdef AQ_DJPEG_MCU_SCHED_DRI_EN
      rst_cnt_d = rst_cnt_q;
`endif
      last_idx  = (JpegComp == 3'd3) ? 3'd5 : 3'd3;
      last_x    = (mcu_x_q == McuWidth - MCU_W'(1));
      last_y    = (mcu_y_q == McuHeight - MCU_W'(1));

      case (state_q)
         S_Idle: begin
            if (ImageEnable) begin
               mcu_x_d   = '0;
               mcu_y_d   = '0;
               blk_idx_d = '0;
               clr_d     = 1'b1;
`ifdef AQ_DJPEG_MCU_SCHED_DRI_EN
               rst_cnt_d = '0;
`endif
               if (McuWidth == '0 || McuHeight == '0) state_d = S_Done;
               else                                   state_d = S_Issue;
            end
         end
         S_Issue: begin
            if (!ImageEnable)  state_d = S_Idle;
            else if (BlkReady) state_d = S_Wait;
         end
         S_Wait: begin
            if (!ImageEnable) state_d = S_Idle;
            else if (BlkDone) state_d = S_Next;
         end
         S_Next: begin
            if (!ImageEnable) begin
               state_d = S_Idle;
            end else if (blk_idx_q != last_idx) begin
               blk_idx_d = blk_idx_q + 3'd1;
               state_d   = S_Issue;
            end else begin
               blk_idx_d = '0;
`ifdef AQ_DJPEG_MCU_SCHED_DRI_EN
               rst_cnt_d = rst_cnt_q + RST_W'(1);
`endif
               if (last_x) begin
                  mcu_x_d = '0;
                  mcu_y_d = mcu_y_q + MCU_W'(1);
               end else begin
                  mcu_x_d = mcu_x_q + MCU_W'(1);
               end
               if (last_x && last_y) state_d = S_Done;
`ifdef AQ_DJPEG_MCU_SCHED_DRI_EN
               else if (RestartInterval != '0 && rst_cnt_q + RST_W'(1) == RestartInterval)
                  state_d = S_Restart;
`endif
               else state_d = S_Issue;
            end
         end
`ifdef AQ_DJPEG_MCU_SCHED_DRI_EN
         S_Restart: begin
            if (!ImageEnable) begin
               state_d = S_Idle;
            end else if (RstMarkerAck) begin
               rst_cnt_d = '0;
               clr_d     = 1'b1;
               state_d   = S_Issue;
            end
         end
`endif
         S_Done: begin
            if (!ImageEnable) state_d = S_Idle;
         end
         default: state_d = S_Idle;
      endcase

      done_d = (state_d == S_Done) && (state_q != S_Done);

      // Descriptor fields are captured only on entry to S_Issue so they hold under backpressure.
      if (state_d == S_Issue && state_q != S_Issue) begin
         comp_d   = comp_of(blk_idx_d, JpegComp == 3'd3);
         dqt_d    = (comp_d != 2'd0);
         dc_sel_d = (comp_d != 2'd0) ? 2'b10 : 2'b00;
         ac_sel_d = (comp_d != 2'd0) ? 2'b11 : 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_Idle;
         mcu_x_q   <= '0;
         mcu_y_q   <= '0;
         blk_idx_q <= '0;
         comp_q    <= '0;
         dqt_q     <= 1'b0;
         dc_sel_q  <= '0;
         ac_sel_q  <= '0;
         clr_q     <= 1'b0;
         done_q    <= 1'b0;
`ifdef AQ_DJPEG_MCU_SCHED_DRI_EN
         rst_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         mcu_x_q   <= mcu_x_d;
         mcu_y_q   <= mcu_y_d;
         blk_idx_q <= blk_idx_d;
         comp_q    <= comp_d;
         dqt_q     <= dqt_d;
         dc_sel_q  <= dc_sel_d;
         ac_sel_q  <= ac_sel_d;
         clr_q     <= clr_d;
         done_q    <= done_d;
`ifdef AQ_DJPEG_MCU_SCHED_DRI_EN
         rst_cnt_q <= rst_cnt_d;
`endif
      end
   end

   assign BlkValid  = (state_q == S_Issue);
   assign SchedIdle = (state_q == S_Idle);
   assign BlkComp   = comp_q;
   assign BlkIndex  = blk_idx_q;
   assign DqtSel    = dqt_q;
   assign DhtDcSel  = dc_sel_q;
   assign DhtAcSel  = ac_sel_q;
   assign McuX      = mcu_x_q;
   assign McuY      = mcu_y_q;
   assign DcPredClr = clr_q;
   assign SchedDone = done_q;
`ifdef AQ_DJPEG_MCU_SCHED_DRI_EN
   assign RstMarkerReq = (state_q == S_Restart);
`else
   assign RstMarkerReq = 1'b0;
`endif

endmodule

// File: tb/tb_aq_djpeg_mcu_sched.sv
// Bench for aq_djpeg_mcu_sched: expected descriptor stream built from nested raster loops.
module tb_aq_djpeg_mcu_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ImageEnable = 1'b0;
   logic [2:0]  JpegComp = '0;
   logic [11:0] McuWidth = '0;
   logic [11:0] McuHeight = '0;
   logic [15:0] RestartInterval = '0;
   logic        BlkReady = 1'b0;
   logic        BlkDone = 1'b0;
   logic        RstMarkerAck = 1'b0;
   logic        BlkValid, DqtSel, RstMarkerReq, DcPredClr, SchedDone, SchedIdle;
   logic [1:0]  BlkComp, DhtDcSel, DhtAcSel;
   logic [2:0]  BlkIndex;
   logic [11:0] McuX, McuY;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int comp; int idx; int dqt; int dc; int ac; int x; int y;
   } desc_t;
   desc_t exp_q[$];

   aq_djpeg_mcu_sched #(.MCU_W(12), .RST_W(16)) dut (
      .clk(clk), .rst(rst), .ImageEnable(ImageEnable), .JpegComp(JpegComp),
      .McuWidth(McuWidth), .McuHeight(McuHeight), .RestartInterval(RestartInterval),
      .BlkValid(BlkValid), .BlkReady(BlkReady), .BlkDone(BlkDone),
      .BlkComp(BlkComp), .BlkIndex(BlkIndex), .DqtSel(DqtSel),
      .DhtDcSel(DhtDcSel), .DhtAcSel(DhtAcSel), .McuX(McuX), .McuY(McuY),
      .RstMarkerReq(RstMarkerReq), .RstMarkerAck(RstMarkerAck),
      .DcPredClr(DcPredClr), .SchedDone(SchedDone), .SchedIdle(SchedIdle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_image(input int w, input int h, input int jc, input int ri,
                            input bit rnd, input bit stall5);
      int nb, total, exp_rst, n_desc, done_cd, ack_cd, n_done, n_req, n_clr;
      int last_done_cyc, done_cyc, vcyc, blocks_done;
      bit prev_valid, prev_req, ready;
      logic [33:0] prev_pack, cur_pack;
      desc_t d;
      nb = (jc == 3) ? 6 : 4;
      exp_q.delete();
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            for (int b = 0; b < nb; b++) begin
               d.comp = (jc == 3 && b >= 4) ? b - 3 : 0;
               d.idx  = b;
               d.dqt  = (d.comp != 0) ? 1 : 0;
               d.dc   = (d.comp != 0) ? 2 : 0;
               d.ac   = (d.comp != 0) ? 3 : 1;
               d.x    = x;
               d.y    = y;
               exp_q.push_back(d);
            end
      total = exp_q.size();
      exp_rst = 0;
`ifdef AQ_DJPEG_MCU_SCHED_DRI_EN
      if (ri != 0)
         for (int m = 1; m < w * h; m++) if (m % ri == 0) exp_rst++;
`endif
      JpegComp = 3'(jc); McuWidth = 12'(w); McuHeight = 12'(h); RestartInterval = 16'(ri);
      ImageEnable = 1'b1;
      n_desc = 0; done_cd = 0; ack_cd = 0; n_done = 0; n_req = 0; n_clr = 0;
      last_done_cyc = -100; done_cyc = -1; vcyc = 0; blocks_done = 0;
      prev_valid = 0; prev_req = 0; prev_pack = '0;
      for (int c = 0; c < 6000 && !(n_done > 0 && c > done_cyc + 3); c++) begin
         step();
         if (c == 0) begin
            chk("start_valid", 32'(BlkValid), 32'(w != 0 && h != 0));
            chk("start_dcclr", 32'(DcPredClr), 32'd1);
         end
         if (DcPredClr) n_clr++;
         if (SchedDone) begin n_done++; done_cyc = c; end
         if (RstMarkerReq && !prev_req) begin
            n_req++;
            chk("rst_req_pos", 32'(ri != 0 && blocks_done % (ri * nb) == 0), 32'd1);
            ack_cd = $urandom_range(0, 4);
         end
         prev_req = RstMarkerReq;
         RstMarkerAck = 1'b0;
         if (RstMarkerReq) begin
            if (ack_cd == 0) RstMarkerAck = 1'b1;
            else ack_cd--;
         end
         BlkDone = 1'b0;
         if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) begin
               BlkDone = 1'b1; last_done_cyc = c; blocks_done++;
            end
         end
         if (BlkValid) begin
            cur_pack = {BlkComp, BlkIndex, DqtSel, DhtDcSel, DhtAcSel, McuX, McuY};
            if (prev_valid) chk("hold_fields", 32'(cur_pack ^ prev_pack), 32'd0);
            prev_pack = cur_pack;
            vcyc++;
            if (stall5 && n_desc == 0) ready = (vcyc >= 6);
            else if (rnd)              ready = ($urandom_range(0, 2) != 0);
            else                       ready = 1'b1;
            if (ready) begin
               if (stall5 && n_desc == 0) chk("stall_hs_cycle", 32'(vcyc), 32'd6);
               if (exp_q.size() == 0) begin
                  chk("extra_desc", 32'd1, 32'd0);
               end else begin
                  d = exp_q.pop_front();
                  chk("comp", 32'(BlkComp), 32'(d.comp));
                  chk("index", 32'(BlkIndex), 32'(d.idx));
                  chk("dqt", 32'(DqtSel), 32'(d.dqt));
                  chk("dhtdc", 32'(DhtDcSel), 32'(d.dc));
                  chk("dhtac", 32'(DhtAcSel), 32'(d.ac));
                  chk("mcux", 32'(McuX), 32'(d.x));
                  chk("mcuy", 32'(McuY), 32'(d.y));
               end
               n_desc++;
               done_cd = $urandom_range(1, 4);
               vcyc = 0;
               prev_valid = 0;
            end else begin
               prev_valid = 1;
            end
            BlkReady = ready;
         end else begin
            prev_valid = 0;
            BlkReady = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      BlkReady = 1'b0; BlkDone = 1'b0; RstMarkerAck = 1'b0;
      chk("desc_count", 32'(n_desc), 32'(total));
      chk("desc_left", 32'(exp_q.size()), 32'd0);
      chk("done_pulses", 32'(n_done), 32'd1);
      chk("rst_reqs", 32'(n_req), 32'(exp_rst));
      chk("dcclr_pulses", 32'(n_clr), 32'(1 + exp_rst));
      if (total > 0) chk("done_latency", 32'(done_cyc - last_done_cyc), 32'd2);
      else           chk("zero_done_early", 32'(done_cyc >= 0 && done_cyc <= 2), 32'd1);
      ImageEnable = 1'b0;
      step();
      step();
      chk("idle_after", 32'(SchedIdle), 32'd1);
   endtask

   initial begin
      int n_sd;
      bit reached;
      // reset state
      rst = 1'b0;
      step();
      step();
      chk("rst_idle", 32'(SchedIdle), 32'd1);
      chk("rst_valid", 32'(BlkValid), 32'd0);
      chk("rst_ac", 32'(DhtAcSel), 32'd0);
      chk("rst_comp", 32'(BlkComp), 32'd0);
      chk("rst_mcux", 32'(McuX), 32'd0);
      chk("rst_done", 32'(SchedDone), 32'd0);
      chk("rst_dcclr", 32'(DcPredClr), 32'd0);
      chk("rst_req", 32'(RstMarkerReq), 32'd0);
      rst = 1'b1;
      step();

      run_image(1, 1, 3, 0, 0, 0);
      run_image(2, 2, 1, 0, 0, 0);
      run_image(3, 1, 3, 2, 0, 0);
      run_image(2, 1, 3, 0, 0, 1);

      // abort in S_Wait with a coincident BlkDone
      JpegComp = 3'd3; McuWidth = 12'd2; McuHeight = 12'd1; RestartInterval = '0;
      ImageEnable = 1'b1; BlkReady = 1'b1;
      step();
      step();
      BlkReady = 1'b0;
      chk("abort_pre_busy", 32'(SchedIdle | BlkValid), 32'd0);
      ImageEnable = 1'b0; BlkDone = 1'b1;
      step();
      BlkDone = 1'b0;
      chk("abort_idle", 32'(SchedIdle), 32'd1);
      chk("abort_valid", 32'(BlkValid), 32'd0);
      n_sd = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (SchedDone) n_sd++;
      end
      chk("abort_no_done", 32'(n_sd), 32'd0);
      run_image(2, 1, 3, 0, 1, 0);

      for (int k = 0; k < 5; k++)
         run_image($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 7),
                   $urandom_range(0, 3), 1, 0);

      run_image(0, 2, 3, 0, 0, 0);
      run_image(3, 0, 1, 1, 0, 0);

      // synchronous reset while mid-image
      JpegComp = 3'd3; McuWidth = 12'd3; McuHeight = 12'd1; RestartInterval = 16'd1;
      ImageEnable = 1'b1; BlkReady = 1'b1; BlkDone = 1'b1;
      reached = 0;
      for (int i = 0; i < 200 && !reached; i++) begin
         step();
`ifdef AQ_DJPEG_MCU_SCHED_DRI_EN
         reached = RstMarkerReq;
`else
         reached = (McuX == 12'd1);
`endif
      end
      chk("reset_target_reached", 32'(reached), 32'd1);
      BlkReady = 1'b0; BlkDone = 1'b0;
      rst = 1'b0;
      step();
      chk("midrst_idle", 32'(SchedIdle), 32'd1);
      chk("midrst_req", 32'(RstMarkerReq), 32'd0);
      chk("midrst_valid", 32'(BlkValid), 32'd0);
      chk("midrst_mcux", 32'(McuX), 32'd0);
      rst = 1'b1;
      ImageEnable = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
